// File: rtl/eight_bit_adder_pkg.sv
// ============================================================================
// Module   : eight_bit_adder_pkg
// Purpose  : Shared width constant and word type for the eight_bit_adder slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package eight_bit_adder_pkg;
  localparam int WIDTH = 8;
  typedef logic [WIDTH-1:0] word_t;
endpackage

`default_nettype wire

// File: rtl/eight_bit_adder_full_adder.sv
// ============================================================================
// Module   : full_adder
// Purpose  : One-bit full adder cell, chained by eight_bit_adder into a ripple.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/eight_bit_adder.sv
// ============================================================================
// Module   : eight_bit_adder
// Purpose  : Registered 8-bit ripple-carry adder/subtractor, one-cycle latency.
//            Optional signed-overflow output enabled by defining ADDER_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eight_bit_adder
  import eight_bit_adder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin0,
  input  logic       subtract,
  output logic       out_valid,
  output logic [7:0] sum,
`ifdef ADDER_OVF_EN
  output logic       ovf,
`endif
  output logic       c7
);

  word_t            bx;
  logic             ci;
  logic [WIDTH:0]   carry;
  word_t            sum_n;
  logic             c7_n;

  word_t            sum_d, sum_q;
  logic             c7_d, c7_q;
  logic             out_valid_d, out_valid_q;

  // Subtraction is a + ~b + 1; cin0 then acts as a borrow, hence the XOR.
  assign bx       = b ^ {WIDTH{subtract}};
  assign ci       = cin0 ^ subtract;
  assign carry[0] = ci;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
      full_adder u_fa (
        .a    (a[i]),
        .b    (bx[i]),
        .cin  (carry[i]),
        .s    (sum_n[i]),
        .cout (carry[i+1])
      );
    end
  endgenerate

  assign c7_n = carry[WIDTH];

  always_comb begin
    sum_d       = sum_q;
    c7_d        = c7_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d = sum_n;
      c7_d  = c7_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= '0;
      c7_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      c7_q        <= c7_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign c7        = c7_q;
  assign out_valid = out_valid_q;

`ifdef ADDER_OVF_EN
  logic ovf_n, ovf_d, ovf_q;

  // Operands of equal sign producing a result of the other sign.
  assign ovf_n = (a[WIDTH-1] == bx[WIDTH-1]) && (sum_n[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) ovf_d = ovf_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_eight_bit_adder.sv
// Directed and random checks of eight_bit_adder; ovf checks only when ADDER_OVF_EN is defined.
`default_nettype none

module tb_eight_bit_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a, b;
  logic       cin0, subtract;
  logic       out_valid, c7;
  logic [7:0] sum;
`ifdef ADDER_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_passed = 0;

  always #5 clk = ~clk;

  eight_bit_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin0      (cin0),
    .subtract  (subtract),
    .out_valid (out_valid),
    .sum       (sum),
`ifdef ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .c7        (c7)
  );

  // Present one operation at the falling edge, then land #1 after the capturing edge.
  task automatic drive(input logic v, input logic [7:0] va, input logic [7:0] vb,
                       input logic vc, input logic vs);
    @(negedge clk);
    in_valid = v; a = va; b = vb; cin0 = vc; subtract = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
    n_checks++;
    if ({out_valid, c7, sum} !== 10'b0_0_0000_0000)
      $display("FAIL reset_priority: got ov=%b c7=%b sum=%h, want ov=0 c7=0 sum=00",
               out_valid, c7, sum);
    else n_passed++;
`ifdef ADDER_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf);
    else n_passed++;
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic [7:0] va [4] = '{8'hAA, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] vb [4] = '{8'h55, 8'h01, 8'h01, 8'hFF};
    logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [8:0] ex [4] = '{9'h0FF, 9'h100, 9'h101, 9'h1FF};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, va[i], vb[i], vc[i], 1'b0);
      n_checks++;
      if ({out_valid, c7, sum} !== {1'b1, ex[i]})
        $display("FAIL add_%0d: got ov=%b c7=%b sum=%h, want ov=1 c7=%b sum=%h",
                 i, out_valid, c7, sum, ex[i][8], ex[i][7:0]);
      else n_passed++;
    end
  endtask

  task automatic test_sub;
    logic [7:0] va [4] = '{8'h10, 8'h01, 8'h05, 8'h05};
    logic [7:0] vb [4] = '{8'h01, 8'h02, 8'h05, 8'h04};
    logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [8:0] ex [4] = '{9'h10F, 9'h0FF, 9'h0FF, 9'h100};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, va[i], vb[i], vc[i], 1'b1);
      n_checks++;
      if ({out_valid, c7, sum} !== {1'b1, ex[i]})
        $display("FAIL sub_%0d: got ov=%b c7=%b sum=%h, want ov=1 c7=%b sum=%h",
                 i, out_valid, c7, sum, ex[i][8], ex[i][7:0]);
      else n_passed++;
    end
  endtask

  task automatic test_hold;
    drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    drive(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
    n_checks++;
    if ({out_valid, c7, sum} !== {1'b0, 1'b0, 8'h46})
      $display("FAIL hold: got ov=%b c7=%b sum=%h, want ov=0 c7=0 sum=46",
               out_valid, c7, sum);
    else n_passed++;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    n_checks++;
    if ({out_valid, c7, sum} !== 10'b0)
      $display("FAIL reset_idle: got ov=%b c7=%b sum=%h, want ov=0 c7=0 sum=00",
               out_valid, c7, sum);
    else n_passed++;
  endtask

`ifdef ADDER_OVF_EN
  task automatic test_ovf;
    logic [7:0] va [4] = '{8'h7F, 8'h80, 8'h01, 8'h80};
    logic [7:0] vb [4] = '{8'h01, 8'h01, 8'h01, 8'h80};
    logic       vs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] es [4] = '{8'h80, 8'h7F, 8'h02, 8'h00};
    logic       eo [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, va[i], vb[i], 1'b0, vs[i]);
      n_checks++;
      if ({ovf, sum} !== {eo[i], es[i]})
        $display("FAIL ovf_%0d: got ovf=%b sum=%h, want ovf=%b sum=%h",
                 i, ovf, sum, eo[i], es[i]);
      else n_passed++;
    end
  endtask
`endif

  // Independent arithmetic model: integer add, or integer compare for borrow.
  task automatic test_random;
    int fails = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] va, vb, esum;
      logic vc, vs, ec7;
      int ia, ib, r;
      va = 8'($urandom); vb = 8'($urandom);
      vc = 1'($urandom); vs = 1'($urandom);
      ia = int'(va); ib = int'(vb);
      if (vs) begin
        r   = ia - ib - int'(vc);
        ec7 = (ia >= ib + int'(vc));
      end else begin
        r   = ia + ib + int'(vc);
        ec7 = (r > 255);
      end
      esum = 8'(r);
      drive(1'b1, va, vb, vc, vs);
      n_checks++;
      if ({out_valid, c7, sum} !== {1'b1, ec7, esum}) begin
        if (fails < 10)
          $display("FAIL random_%0d: a=%h b=%h cin=%b sub=%b got c7=%b sum=%h, want c7=%b sum=%h",
                   i, va, vb, vc, vs, c7, sum, ec7, esum);
        fails++;
      end else n_passed++;
`ifdef ADDER_OVF_EN
      begin
        int sr;
        logic eovf;
        sr = vs ? ($signed(va) - $signed(vb) - int'(vc))
                : ($signed(va) + $signed(vb) + int'(vc));
        eovf = (sr > 127) || (sr < -128);
        n_checks++;
        if (ovf !== eovf) begin
          if (fails < 10)
            $display("FAIL random_ovf_%0d: got %b want %b", i, ovf, eovf);
          fails++;
        end else n_passed++;
      end
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin0 = 1'b0; subtract = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_hold();
`ifdef ADDER_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
